bufgctrl_switch_seq: RTL and testbench
======================================

// Module: bufgctrl_switch_seq
// PURPOSE
//  Sequencer driving the select/enable/ignore pins of one BUFGCTRL global clock mux.
//  Accepts clock-source switch requests over a valid/ready handshake and runs a glitch-free
//  break-before-make sequence: drop old select, wait OFF_CYCLES, raise new select, wait ON_CYCLES.
//  Runs on a free-running control clock, not on either muxed clock; CLK*_ALIVE come pre-synchronized.
// PARAMETERS
//  INIT_SEL    0   source selected out of reset (0 -> I0, 1 -> I1)
//  OFF_CYCLES  8   CLK cycles both selects held low before new select rises (>=1)
//  ON_CYCLES   8   CLK cycles after new select rises before switch is reported done (>=1)
//  CNT_W       8   settle-counter width; must hold max(OFF_CYCLES, ON_CYCLES)
// PORTS
//  CLK        in   1  control clock
//  RST_N      in   1  synchronous reset, active low
//  REQ_VALID  in   1  switch request valid
//  REQ_SEL    in   1  requested source (0 -> I0, 1 -> I1)
//  REQ_FORCE  in   1  drive IGNORE on the old source (old clock may be stopped)
//  REQ_READY  out  1  request accepted when REQ_VALID & REQ_READY
//  CLK0_ALIVE in   1  I0 source running (synchronized status)
//  CLK1_ALIVE in   1  I1 source running (synchronized status)
//  GATE       in   1  level: deassert both CE while idle (global clock stopped)
//  S0,S1      out  1  to BUFGCTRL S0/S1
//  CE0,CE1    out  1  to BUFGCTRL CE0/CE1
//  IGNORE0,1  out  1  to BUFGCTRL IGNORE0/IGNORE1
//  CUR_SEL    out  1  committed active source
//  BUSY       out  1  sequence in progress
//  DONE       out  1  1-cycle pulse: request completed (switched or already selected)
//  ERR        out  1  1-cycle pulse: request rejected or aborted
// BEHAVIOUR
//  All outputs registered. Reset (RST_N=0 at CLK edge): CUR_SEL=INIT_SEL, S_INIT_SEL=1,
//   other S=0, CE0=CE1=1, IGNORE0=IGNORE1=0, BUSY=DONE=ERR=0, REQ_READY=1, state IDLE.
//  Reset mid-sequence: same values next cycle; in-flight request discarded, no DONE/ERR.
//  States: IDLE -> DESEL -> WAIT_OFF -> WAIT_ON -> IDLE. Notation: c=CUR_SEL, t=REQ_SEL, N=accept cycle.
//  IDLE: REQ_READY=1; CE0=CE1=~GATE. On accept at N:
//   - t==c: DONE=1 at N+1, no pin change.
//   - t!=c and CLKt_ALIVE=0: ERR=1 at N+1, no pin change.
//   - otherwise: latch t and REQ_FORCE, go DESEL.
//  REQ_READY=0 from N+1 until DONE/ERR cycle; REQ_VALID ignored while not ready.
//  DESEL: at N+1 S_c=0, CE0=CE1=1 (GATE ignored while busy), IGNORE_c=REQ_FORCE, BUSY=1.
//  WAIT_OFF: both S low; S_t rises at N+1+OFF_CYCLES (state WAIT_ON entered).
//  WAIT_ON: DONE=1, CUR_SEL=t, IGNORE cleared, BUSY=0, REQ_READY=1 at N+1+OFF_CYCLES+ON_CYCLES.
//  Abort: CLKt_ALIVE=0 in any cycle of WAIT_OFF/WAIT_ON -> next cycle S_t=0, S_c=1,
//   IGNORE cleared, ERR=1, BUSY=0, CUR_SEL unchanged, IDLE.
//  Invariant: S0 & S1 never both 1 in any cycle. DONE and ERR never both 1.
//  Counter: loaded with OFF_CYCLES-1 / ON_CYCLES-1, decrements, transitions at 0; no wrap.
//  GATE changes while busy take effect in first IDLE cycle after completion.
// TESTING (OFF_CYCLES=4, ON_CYCLES=3, INIT_SEL=0)
//  Reset release -> S0=1,S1=0,CE0=CE1=1,CUR_SEL=0,REQ_READY=1, no DONE/ERR.
//  Accept SEL=1 at N, both alive -> S0=0 @N+1; S1=1 @N+5; DONE,CUR_SEL=1 @N+8; S0&S1 never 1.
//  Accept SEL=0 while CUR_SEL=0 -> DONE @N+1, pins unchanged; SEL=1 with CLK1_ALIVE=0 -> ERR @N+1.
//  CLK1_ALIVE drops @N+6 during switch to 1 -> @N+7 S1=0,S0=1,ERR=1,CUR_SEL=0; REQ_VALID held
//   during busy not accepted until N+7.
//  REQ_FORCE=1 switch 0->1 -> IGNORE0=1 from N+1 through N+7, 0 @N+8; GATE=1 idle -> CE0=CE1=0.
//  RST_N=0 @N+3 mid-switch -> next cycle S0=1,S1=0,BUSY=0,IGNORE=0, no DONE/ERR pulse.

Source files
------------

// File: rtl/bufgctrl_switch_seq.sv
// -----------------------------------------------------------------------------
// bufgctrl_switch_seq
//   Drives the S0/S1, CE0/CE1 and IGNORE0/IGNORE1 pins of a single BUFGCTRL
//   global clock mux. A switch request is taken over a valid/ready handshake and
//   is carried out as a break-before-make sequence: the old select drops, both
//   selects stay low for OFF_CYCLES, the new select rises, and the switch is
//   reported done ON_CYCLES later. The block runs on a free-running control
//   clock. CLK0_ALIVE/CLK1_ALIVE are expected to be synchronized already.
//
// Ports
//   CLK, RST_N            control clock, synchronous active-low reset
//   REQ_VALID/REQ_READY   request handshake
//   REQ_SEL               requested source (0 -> I0, 1 -> I1)
//   REQ_FORCE             assert IGNORE on the old source during the switch
//   CLK0_ALIVE/CLK1_ALIVE source running status
//   GATE                  level: stop the global clock (both CE low) while idle
//   S0,S1,CE0,CE1         BUFGCTRL select and enable pins
//   IGNORE0,IGNORE1       BUFGCTRL ignore pins
//   CUR_SEL               committed active source
//   BUSY                  switch sequence in progress
//   DONE / ERR            one-cycle completion / rejection-or-abort pulses
// -----------------------------------------------------------------------------
module bufgctrl_switch_seq #(
   parameter int INIT_SEL   = 0,
   parameter int OFF_CYCLES = 8,
   parameter int ON_CYCLES  = 8,
   parameter int CNT_W      = 8
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic REQ_VALID,
   input  logic REQ_SEL,
   input  logic REQ_FORCE,
   output logic REQ_READY,
   input  logic CLK0_ALIVE,
   input  logic CLK1_ALIVE,
   input  logic GATE,
   output logic S0,
   output logic S1,
   output logic CE0,
   output logic CE1,
   output logic IGNORE0,
   output logic IGNORE1,
   output logic CUR_SEL,
   output logic BUSY,
   output logic DONE,
   output logic ERR
);

   typedef enum logic [1:0] {IDLE, DESEL, WAIT_OFF, WAIT_ON} state_t;

   localparam logic             INIT_B   = (INIT_SEL != 0);
   localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);
   localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             tgt, tgt_nxt;
   logic             cur, cur_nxt;
   logic [1:0]       sel, sel_nxt;   // {S1, S0}
   logic [1:0]       ce, ce_nxt;     // {CE1, CE0}
   logic [1:0]       ign, ign_nxt;   // {IGNORE1, IGNORE0}
   logic             busy, busy_nxt;
   logic             done, done_nxt;
   logic             err, err_nxt;
   logic             rdy, rdy_nxt;
   logic [1:0]       alive;

   assign alive = {CLK1_ALIVE, CLK0_ALIVE};

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      tgt_nxt   = tgt;
      cur_nxt   = cur;
      sel_nxt   = sel;
      ce_nxt    = ce;
      ign_nxt   = ign;
      busy_nxt  = busy;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      rdy_nxt   = rdy;

      case (state)
         IDLE: begin
            ce_nxt = {2{~GATE}};
            if (REQ_VALID) begin
               if (REQ_SEL == cur) begin
                  done_nxt = 1'b1;
               end else if (!alive[REQ_SEL]) begin
                  err_nxt = 1'b1;
               end else begin
                  // Break first: old select drops, both enables forced on so
                  // the mux can complete its internal handover.
                  state_nxt = DESEL;
                  tgt_nxt   = REQ_SEL;
                  cnt_nxt   = OFF_LOAD;
                  sel_nxt   = 2'b00;
                  ce_nxt    = 2'b11;
                  ign_nxt   = cur ? {REQ_FORCE, 1'b0} : {1'b0, REQ_FORCE};
                  busy_nxt  = 1'b1;
                  rdy_nxt   = 1'b0;
               end
            end
         end

         DESEL, WAIT_OFF, WAIT_ON: begin
            // DESEL shares the off-count so the new select rises exactly
            // OFF_CYCLES after the old one fell.
            if (state != DESEL && !alive[tgt]) begin
               state_nxt = IDLE;
               sel_nxt   = cur ? 2'b10 : 2'b01;
               ce_nxt    = {2{~GATE}};
               ign_nxt   = 2'b00;
               busy_nxt  = 1'b0;
               err_nxt   = 1'b1;
               rdy_nxt   = 1'b1;
            end else if (state == WAIT_ON) begin
               if (cnt == '0) begin
                  state_nxt = IDLE;
                  cur_nxt   = tgt;
                  ce_nxt    = {2{~GATE}};
                  ign_nxt   = 2'b00;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
                  rdy_nxt   = 1'b1;
               end else begin
                  cnt_nxt = cnt - 1'b1;
               end
            end else begin
               if (cnt == '0) begin
                  state_nxt = WAIT_ON;
                  sel_nxt   = tgt ? 2'b10 : 2'b01;
                  cnt_nxt   = ON_LOAD;
               end else begin
                  state_nxt = WAIT_OFF;
                  cnt_nxt   = cnt - 1'b1;
               end
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state <= IDLE;
         cnt   <= '0;
         tgt   <= INIT_B;
         cur   <= INIT_B;
         sel   <= INIT_B ? 2'b10 : 2'b01;
         ce    <= 2'b11;
         ign   <= 2'b00;
         busy  <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
         rdy   <= 1'b1;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         tgt   <= tgt_nxt;
         cur   <= cur_nxt;
         sel   <= sel_nxt;
         ce    <= ce_nxt;
         ign   <= ign_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
         err   <= err_nxt;
         rdy   <= rdy_nxt;
      end
   end

   assign S0        = sel[0];
   assign S1        = sel[1];
   assign CE0       = ce[0];
   assign CE1       = ce[1];
   assign IGNORE0   = ign[0];
   assign IGNORE1   = ign[1];
   assign CUR_SEL   = cur;
   assign BUSY      = busy;
   assign DONE      = done;
   assign ERR       = err;
   assign REQ_READY = rdy;

endmodule

// File: tb/tb_bufgctrl_switch_seq.sv
// -----------------------------------------------------------------------------
// tb_bufgctrl_switch_seq
//   Bench for bufgctrl_switch_seq with OFF_CYCLES=4, ON_CYCLES=3, INIT_SEL=0.
//   Each vector row holds the inputs for one control-clock cycle and the
//   registered outputs expected in the following cycle. Expected outputs are
//   packed as {S0,S1, CE0,CE1, IGNORE0,IGNORE1, CUR_SEL, BUSY, DONE, ERR, READY}.
// -----------------------------------------------------------------------------
module tb_bufgctrl_switch_seq;

   logic CLK = 1'b0;
   logic RST_N, REQ_VALID, REQ_SEL, REQ_FORCE, REQ_READY;
   logic CLK0_ALIVE, CLK1_ALIVE, GATE;
   logic S0, S1, CE0, CE1, IGNORE0, IGNORE1, CUR_SEL, BUSY, DONE, ERR;

   always #5 CLK = ~CLK;

   bufgctrl_switch_seq #(
      .INIT_SEL  (0),
      .OFF_CYCLES(4),
      .ON_CYCLES (3),
      .CNT_W     (8)
   ) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .REQ_VALID (REQ_VALID),
      .REQ_SEL   (REQ_SEL),
      .REQ_FORCE (REQ_FORCE),
      .REQ_READY (REQ_READY),
      .CLK0_ALIVE(CLK0_ALIVE),
      .CLK1_ALIVE(CLK1_ALIVE),
      .GATE      (GATE),
      .S0        (S0),
      .S1        (S1),
      .CE0       (CE0),
      .CE1       (CE1),
      .IGNORE0   (IGNORE0),
      .IGNORE1   (IGNORE1),
      .CUR_SEL   (CUR_SEL),
      .BUSY      (BUSY),
      .DONE      (DONE),
      .ERR       (ERR)
   );

   typedef struct {
      string      tag;
      logic       rst_n, valid, sel, frc, a0, a1, gate;
      logic [10:0] exp;
   } vec_t;

   typedef struct {
      string      tag;
      logic [10:0] exp;
   } sb_t;

   vec_t vecs[$];
   sb_t  sb[$];
   int   checks = 0;
   int   errors = 0;

   localparam logic [10:0] IDLE0  = 11'b10_11_00_0_0_0_0_1;
   localparam logic [10:0] BUSY01 = 11'b00_11_00_0_1_0_0_0;

   task automatic add(input string tag, input int n,
                      input logic r, input logic v, input logic s, input logic f,
                      input logic a0, input logic a1, input logic g,
                      input logic [10:0] e);
      vec_t x;
      x.tag = tag; x.rst_n = r; x.valid = v; x.sel = s; x.frc = f;
      x.a0 = a0; x.a1 = a1; x.gate = g; x.exp = e;
      for (int i = 0; i < n; i++) vecs.push_back(x);
   endtask

   initial begin
      logic [10:0] got;
      sb_t         item;

      // ---- single-cycle behaviour ----
      add("reset",            2, 0,0,0,0, 1,1,0, IDLE0);
      add("idle_after_reset", 2, 1,0,0,0, 1,1,0, IDLE0);
      add("same_sel_done",    1, 1,1,0,0, 1,1,0, 11'b10_11_00_0_0_1_0_1);
      add("dead_target_err",  1, 1,1,1,0, 1,0,0, 11'b10_11_00_0_0_0_1_1);
      add("gate_idle",        1, 1,0,0,0, 1,1,1, 11'b10_00_00_0_0_0_0_1);
      add("ungate_idle",      1, 1,0,0,0, 1,1,0, IDLE0);

      // ---- forced switch 0->1, GATE toggled while busy ----
      add("force_accept",     1, 1,1,1,1, 1,1,0, 11'b00_11_10_0_1_0_0_0);
      add("force_off",        3, 1,0,0,0, 1,1,1, 11'b00_11_10_0_1_0_0_0);
      add("force_on",         3, 1,0,0,0, 1,1,1, 11'b01_11_10_0_1_0_0_0);
      add("force_done",       1, 1,0,0,0, 1,1,0, 11'b01_11_00_1_0_1_0_1);
      add("idle1_gated",      1, 1,0,0,0, 1,1,1, 11'b01_00_00_1_0_0_0_1);
      add("sel1_done",        1, 1,1,1,0, 1,1,0, 11'b01_11_00_1_0_1_0_1);
      add("dead0_err",        1, 1,1,0,0, 0,1,0, 11'b01_11_00_1_0_0_1_1);

      // ---- plain switch 1->0 ----
      add("back_accept",      1, 1,1,0,0, 1,1,0, 11'b00_11_00_1_1_0_0_0);
      add("back_off",         3, 1,0,0,0, 1,1,0, 11'b00_11_00_1_1_0_0_0);
      add("back_on",          3, 1,0,0,0, 1,1,0, 11'b10_11_00_1_1_0_0_0);
      add("back_done",        1, 1,0,0,0, 1,1,0, 11'b10_11_00_0_0_1_0_1);

      // ---- abort in WAIT_ON, request held valid throughout ----
      add("abort_accept",     1, 1,1,1,0, 1,1,0, BUSY01);
      add("abort_held_off",   3, 1,1,1,0, 1,1,0, BUSY01);
      add("abort_held_on",    2, 1,1,1,0, 1,1,0, 11'b01_11_00_0_1_0_0_0);
      add("abort_drop",       1, 1,1,1,0, 1,0,0, 11'b10_11_00_0_0_0_1_1);
      add("abort_held_taken", 1, 1,1,1,0, 1,0,0, 11'b10_11_00_0_0_0_1_1);
      add("after_abort",      1, 1,0,0,0, 1,1,0, IDLE0);

      // ---- abort in WAIT_OFF ----
      add("woff_accept",      1, 1,1,1,0, 1,1,0, BUSY01);
      add("woff_desel",       1, 1,0,0,0, 1,1,0, BUSY01);
      add("woff_drop",        1, 1,0,0,0, 1,0,0, 11'b10_11_00_0_0_0_1_1);
      add("woff_idle",        1, 1,0,0,0, 1,1,0, IDLE0);

      // ---- reset in the middle of a forced switch ----
      add("rst_accept",       1, 1,1,1,1, 1,1,0, 11'b00_11_10_0_1_0_0_0);
      add("rst_busy",         2, 1,0,0,0, 1,1,0, 11'b00_11_10_0_1_0_0_0);
      add("rst_mid",          1, 0,0,0,0, 1,1,1, IDLE0);
      add("rst_release",      2, 1,0,0,0, 1,1,0, IDLE0);

      for (int i = 0; i < vecs.size(); i++) begin
         RST_N      = vecs[i].rst_n;
         REQ_VALID  = vecs[i].valid;
         REQ_SEL    = vecs[i].sel;
         REQ_FORCE  = vecs[i].frc;
         CLK0_ALIVE = vecs[i].a0;
         CLK1_ALIVE = vecs[i].a1;
         GATE       = vecs[i].gate;
         item.tag   = vecs[i].tag;
         item.exp   = vecs[i].exp;
         sb.push_back(item);

         @(posedge CLK);
         #1;
         item = sb.pop_front();
         got  = {S0, S1, CE0, CE1, IGNORE0, IGNORE1, CUR_SEL, BUSY, DONE, ERR, REQ_READY};
         checks++;
         if (got !== item.exp) begin
            errors++;
            $display("FAIL %s (row %0d): outputs got %b expected %b", item.tag, i, got, item.exp);
         end
         checks++;
         if ((S0 & S1) !== 1'b0 || (DONE & ERR) !== 1'b0) begin
            errors++;
            $display("FAIL exclusive_%s (row %0d): S0=%b S1=%b DONE=%b ERR=%b expected no overlap",
                     item.tag, i, S0, S1, DONE, ERR);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
